// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte using request-to-send
// and collects the device acknowledge. Lines are driven open-drain via *_oe.
//
// state     | meaning
// IDLE      | lines released, waiting for write
// INHIBIT   | clock held low to stop the device
// REQ       | clock and data low (request to send)
// SEND      | clock released, data bits shifted out on device clock falls
// ACK       | data released, sample device ack on next fall
// WAIT_IDLE | wait for both lines high before reporting done
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int REQ_CYCLES     = 200,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       write,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int TMR_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FLT_W   = $clog2(FILTER_LEN + 1);

    localparam logic [TMR_W-1:0] INH_LOAD = TMR_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] REQ_LOAD = TMR_W'(REQ_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t           state;
    logic             clk_meta, clk_sync, data_meta, data_sync;
    logic             clk_filt;
    logic [FLT_W-1:0] flt_cnt;
    logic             fall;
    logic [TMR_W-1:0] tmr;
    logic [TMO_W-1:0] tmo_cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       shreg;
    logic             parity;
    logic             nack;
    logic             tmo_hit;

    // Idle lines are high, so the synchronizers reset to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                clk_filt <= clk_sync;
                flt_cnt  <= '0;
                fall     <= clk_filt;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            tmr         <= '0;
            tmo_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            parity      <= 1'b0;
            nack        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (write) begin
                        shreg      <= tx_data;
                        parity     <= ~^tx_data;
                        tmr        <= INH_LOAD;
                        ps2_clk_oe <= 1'b1;
                        busy       <= 1'b1;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (tmr == '0) begin
                        tmr         <= REQ_LOAD;
                        ps2_data_oe <= 1'b1;
                        state       <= REQ;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                REQ: begin
                    // Releasing the clock with data still low presents the start bit.
                    if (tmr == '0) begin
                        ps2_clk_oe <= 1'b0;
                        tmo_cnt    <= '0;
                        bit_idx    <= '0;
                        state      <= SEND;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                SEND, ACK, WAIT_IDLE: begin
                    if (tmo_hit) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        err         <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (state == SEND) begin
                            if (fall) begin
                                if (bit_idx < 4'd8) begin
                                    ps2_data_oe <= ~shreg[bit_idx[2:0]];
                                end else if (bit_idx == 4'd8) begin
                                    ps2_data_oe <= ~parity;
                                end else begin
                                    ps2_data_oe <= 1'b0;
                                end
                                bit_idx <= bit_idx + 1'b1;
                                if (bit_idx == 4'd9) begin
                                    state <= ACK;
                                end
                            end
                        end else if (state == ACK) begin
                            ps2_data_oe <= 1'b0;
                            if (fall) begin
                                nack  <= data_sync;
                                state <= WAIT_IDLE;
                            end
                        end else begin
                            if (clk_filt && data_sync) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                err   <= nack;
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on open-drain lines, a
// table of transfers, and hand-written timeout, glitch, overlap and reset cases.
module tb_ps2_host_tx;

    localparam int INH  = 40;
    localparam int REQ  = 10;
    localparam int FLT  = 4;
    localparam int TMO  = 3000;
    localparam int HALF = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       write = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       clk_line, data_line;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, err;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [9:0] dev_bits;
    bit         dev_started;
    bit         got_done, got_err, busy_ok, rel_ok;
    int         t_inh, t_req;

    typedef struct {
        logic [7:0] data;
        bit         nack;
        bit         exp_par;
        bit         exp_err;
    } vec_t;
    vec_t vecs[6];

    assign clk_line  = dev_clk & ~ps2_clk_oe;
    assign data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .REQ_CYCLES    (REQ),
        .FILTER_LEN    (FLT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .write      (write),
        .ps2_clk_in (clk_line),
        .ps2_data_in(data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Device side: waits for the start bit, clocks in 10 bits, then acks (or not).
    task dev_xfer(input bit nack, input bit glitch);
        dev_bits    = '0;
        dev_started = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (clk_line && !data_line) begin
                dev_started = 1;
                break;
            end
        end
        if (dev_started) begin
            repeat (10) @(negedge clk);
            for (int i = 0; i < 10; i++) begin
                dev_clk = 1'b0;
                repeat (HALF) @(negedge clk);
                dev_bits[i] = data_line;
                dev_clk = 1'b1;
                if (glitch && i == 3) begin
                    repeat (10) @(negedge clk);
                    dev_clk = 1'b0;
                    repeat (3) @(negedge clk);
                    dev_clk = 1'b1;
                    repeat (HALF - 13) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                end
            end
            if (!nack) dev_data = 1'b0;
            repeat (5) @(negedge clk);
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            repeat (5) @(negedge clk);
            dev_data = 1'b1;
            repeat (5) @(negedge clk);
        end
    endtask

    task run_xfer(input logic [7:0] d, input bit nack, input bit glitch, input bit overlap);
        @(negedge clk);
        tx_data = d;
        write   = 1'b1;
        fork
            begin
                @(negedge clk);
                write = 1'b0;
                if (overlap) begin
                    repeat (20) @(negedge clk);
                    tx_data = 8'hAA;
                    write   = 1'b1;
                    @(negedge clk);
                    write = 1'b0;
                    repeat (300) @(negedge clk);
                    write = 1'b1;
                    @(negedge clk);
                    write = 1'b0;
                end
            end
            dev_xfer(nack, glitch);
            begin
                got_done = 0;
                got_err  = 0;
                busy_ok  = 1;
                rel_ok   = 0;
                for (int k = 0; k < 5000; k++) begin
                    @(negedge clk);
                    if (done) begin
                        got_done = 1;
                        got_err  = err;
                        rel_ok   = !ps2_clk_oe && !ps2_data_oe && !busy;
                        break;
                    end
                    if (!busy) busy_ok = 0;
                end
            end
            begin
                int c;
                t_inh = -1;
                t_req = -1;
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (ps2_clk_oe) break;
                end
                c = 0;
                while (!ps2_data_oe && c < 1000) begin
                    @(negedge clk);
                    c++;
                end
                t_inh = c;
                c = 0;
                while (ps2_clk_oe && c < 1000) begin
                    @(negedge clk);
                    c++;
                end
                t_req = c;
            end
        join
    endtask

    initial begin
        int cnt;
        int done_before;
        int nf;
        logic prev;

        vecs[0] = '{8'hED, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h01, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'hF4, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_clk_oe", int'(ps2_clk_oe), 0);
        check("rst_data_oe", int'(ps2_data_oe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_xfer(vecs[i].data, vecs[i].nack, 1'b0, 1'b0);
            check($sformatf("v%0d_started", i), int'(dev_started), 1);
            check($sformatf("v%0d_data", i), int'(dev_bits[7:0]), int'(vecs[i].data));
            check($sformatf("v%0d_parity", i), int'(dev_bits[8]), int'(vecs[i].exp_par));
            check($sformatf("v%0d_stop", i), int'(dev_bits[9]), 1);
            check($sformatf("v%0d_done", i), int'(got_done), 1);
            check($sformatf("v%0d_err", i), int'(got_err), int'(vecs[i].exp_err));
            check($sformatf("v%0d_busy", i), int'(busy_ok), 1);
            check($sformatf("v%0d_released", i), int'(rel_ok), 1);
            check($sformatf("v%0d_t_inhibit", i), t_inh, INH);
            check($sformatf("v%0d_t_req", i), t_req, REQ);
            repeat (20) @(negedge clk);
        end

        // Device never clocks after release.
        @(negedge clk);
        tx_data = 8'h3C;
        write   = 1'b1;
        @(negedge clk);
        write = 1'b0;
        for (int k = 0; k < 200 && !ps2_clk_oe; k++) @(negedge clk);
        for (int k = 0; k < 200 && ps2_clk_oe; k++) @(negedge clk);
        cnt = 0;
        for (int k = 0; k < TMO + 100; k++) begin
            @(negedge clk);
            cnt++;
            if (done) break;
        end
        check("tmo_cycles", cnt, TMO);
        check("tmo_err", int'(err), 1);
        check("tmo_clk_oe", int'(ps2_clk_oe), 0);
        check("tmo_data_oe", int'(ps2_data_oe), 0);
        check("tmo_busy", int'(busy), 0);
        @(negedge clk);
        check("tmo_done_one_cycle", int'(done), 0);
        repeat (20) @(negedge clk);

        // Glitch during SEND must not advance the bit index.
        run_xfer(8'hED, 1'b0, 1'b1, 1'b0);
        check("glitch_data", int'(dev_bits[7:0]), 32'hED);
        check("glitch_parity", int'(dev_bits[8]), 1);
        check("glitch_err", int'(got_err), 0);
        check("glitch_done", int'(got_done), 1);
        repeat (20) @(negedge clk);

        // Writes while busy are dropped.
        run_xfer(8'hED, 1'b0, 1'b0, 1'b1);
        check("ovl_data", int'(dev_bits[7:0]), 32'hED);
        check("ovl_done", int'(got_done), 1);
        check("ovl_err", int'(got_err), 0);
        repeat (200) @(negedge clk);
        check("ovl_no_restart_busy", int'(busy), 0);
        check("ovl_no_restart_clk", int'(ps2_clk_oe), 0);

        // Reset after the 4th device clock fall aborts silently.
        done_before = done_cnt;
        @(negedge clk);
        tx_data = 8'h5A;
        write   = 1'b1;
        fork
            begin
                @(negedge clk);
                write = 1'b0;
            end
            dev_xfer(1'b0, 1'b0);
            begin
                nf   = 0;
                prev = 1'b1;
                for (int k = 0; k < 4000 && nf < 4; k++) begin
                    @(posedge clk);
                    if (prev && !dev_clk) nf++;
                    prev = dev_clk;
                end
                check("rstmid_falls_seen", nf, 4);
                repeat (12) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("rstmid_clk_oe", int'(ps2_clk_oe), 0);
                check("rstmid_data_oe", int'(ps2_data_oe), 0);
                check("rstmid_busy", int'(busy), 0);
                check("rstmid_done", int'(done), 0);
            end
        join
        repeat (20) @(negedge clk);
        check("rstmid_no_done", done_cnt, done_before);

        run_xfer(8'hFF, 1'b0, 1'b0, 1'b0);
        check("post_rst_data", int'(dev_bits[7:0]), 32'hFF);
        check("post_rst_parity", int'(dev_bits[8]), 1);
        check("post_rst_done", int'(got_done), 1);
        check("post_rst_err", int'(got_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
